// File: rtl/ui_menu_keypad_if.sv
// Menu/LCD side bundle of the front-panel keypad controller.
// master: page, val, alt_view, repaint out; lcd_busy in.
interface ui_menu_keypad_if #(
  parameter int NPAGE = 5,
  parameter int VAL_W = 4
);
  localparam int PW = $clog2(NPAGE + 1);

  logic [PW-1:0]          page;
  logic [NPAGE*VAL_W-1:0] val;
  logic                   alt_view;
  logic                   repaint;
  logic                   lcd_busy;

  modport master (
    output page, val, alt_view, repaint,
    input  lcd_busy
  );

  modport slave (
    input  page, val, alt_view, repaint,
    output lcd_busy
  );
endinterface

// File: rtl/ui_menu_keypad.sv
// Keypad sync/debounce/auto-repeat feeding a paged settings menu.
// Ports: clk, rst (async low), btn_in, val_max, btn_evt, lcd (menu/LCD bundle).
module ui_menu_keypad #(
  parameter int                     NBTN     = 4,
  parameter int                     SYNC_STG = 2,
  parameter int                     LOCK_W   = 24,
  parameter int                     RPT_DLY  = 25000000,
  parameter int                     RPT_PER  = 5000000,
  parameter logic [NBTN-1:0]        RPT_MASK = NBTN'(4'b1100),
  parameter int                     NPAGE    = 5,
  parameter int                     VAL_W    = 4,
  parameter logic [NPAGE*VAL_W-1:0] VAL_INIT = '0,
  parameter bit                     WRAP     = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NBTN-1:0]        btn_in,
  input  logic [NPAGE*VAL_W-1:0] val_max,
  output logic [NBTN-1:0]        btn_evt,
  ui_menu_keypad_if.master       lcd
);

  localparam int PW   = $clog2(NPAGE + 1);
  localparam int RMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_T = RW'(RPT_DLY - 1);
  localparam logic [RW-1:0] PER_T = RW'(RPT_PER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOCK,
    S_HOLD,
    S_RPT
  } bst_t;

  logic [NBTN-1:0] evt_d;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    logic [SYNC_STG-1:0] sync_q;
    logic                lvl;
    bst_t                st_q, st_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [RW-1:0]       rcnt_q, rcnt_d;

    assign lvl = sync_q[SYNC_STG-1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '0;
        st_q   <= S_IDLE;
        lock_q <= '0;
        rcnt_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STG-2:0], btn_in[i]};
        st_q   <= st_d;
        lock_q <= lock_d;
        rcnt_q <= rcnt_d;
      end
    end

    // rcnt counts cycles since the last event and saturates
    always_comb begin
      st_d     = st_q;
      lock_d   = lock_q;
      rcnt_d   = rcnt_q;
      evt_d[i] = 1'b0;
      if (rcnt_q != '1) rcnt_d = rcnt_q + 1'b1;
      unique case (st_q)
        S_IDLE: begin
          if (lvl) begin
            evt_d[i] = 1'b1;
            st_d     = S_LOCK;
            lock_d   = '0;
            rcnt_d   = '0;
          end
        end
        S_LOCK: begin
          lock_d = lock_q + 1'b1;
          if (lock_q == '1) st_d = lvl ? S_HOLD : S_IDLE;
        end
        S_HOLD: begin
          if (!lvl) begin
            st_d = S_IDLE;
          end else if (RPT_MASK[i] && rcnt_q >= DLY_T) begin
            evt_d[i] = 1'b1;
            st_d     = S_RPT;
            rcnt_d   = '0;
          end
        end
        S_RPT: begin
          if (!lvl) begin
            st_d = S_IDLE;
          end else if (rcnt_q >= PER_T) begin
            evt_d[i] = 1'b1;
            rcnt_d   = '0;
          end
        end
        default: st_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_evt <= '0;
    else      btn_evt <= evt_d;
  end

  logic [3:0]             ev4, hit;
  logic                   on0, act;
  logic [PW-1:0]          sel, page_d;
  logic [VAL_W-1:0]       cur, mx, nxt;
  logic [NPAGE*VAL_W-1:0] val_d;
  logic                   alt_d, pend_q, pend_d, rep_d;

  // keep only the lowest-index event among the four menu buttons
  assign ev4 = btn_evt[3:0];
  assign hit = ev4 & (~ev4 + 4'd1);
  assign on0 = (lcd.page == '0);
  assign sel = on0 ? '0 : lcd.page - 1'b1;
  assign cur = lcd.val[sel*VAL_W +: VAL_W];
  assign mx  = val_max[sel*VAL_W +: VAL_W];

  always_comb begin
    page_d = lcd.page;
    alt_d  = lcd.alt_view;
    val_d  = lcd.val;
    nxt    = cur;
    act    = 1'b0;
    unique case (1'b1)
      hit[0]: begin
        act = 1'b1;
        if (on0 || lcd.page == PW'(NPAGE)) page_d = PW'(1);
        else page_d = lcd.page + 1'b1;
      end
      hit[1]: begin
        act = 1'b1;
        if (on0) alt_d = ~lcd.alt_view;
        else page_d = '0;
      end
      hit[2]: begin
        if (!on0) begin
          act = 1'b1;
          if (cur >= mx) nxt = WRAP ? '0 : mx;
          else nxt = cur + 1'b1;
        end
      end
      hit[3]: begin
        if (!on0) begin
          act = 1'b1;
          if (cur == '0) nxt = WRAP ? mx : '0;
          else nxt = cur - 1'b1;
        end
      end
      default: ;
    endcase
    val_d[sel*VAL_W +: VAL_W] = nxt;
  end

  // the repaint_q term keeps repaint pulses at least one cycle apart
  assign rep_d  = pend_q & ~lcd.lcd_busy & ~lcd.repaint;
  assign pend_d = act | (pend_q & ~rep_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcd.page     <= '0;
      lcd.val      <= VAL_INIT;
      lcd.alt_view <= 1'b0;
      lcd.repaint  <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      lcd.page     <= page_d;
      lcd.val      <= val_d;
      lcd.alt_view <= alt_d;
      lcd.repaint  <= rep_d;
      pend_q       <= pend_d;
    end
  end

endmodule
